// File: rtl/reg8_serial_reader_if.sv
// rtl/reg8_serial_reader_if.sv - request/word/serial-stream bundle for reg8_serial_reader
// master = requester and bit consumer, slave = the reader.
interface reg8_serial_reader_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] d;
   logic             sout;
   logic             sout_valid;
   logic             sout_ready;
   logic             busy;
   logic             done;

   modport master (
      output start, d, sout_ready,
      input  sout, sout_valid, busy, done
   );

   modport slave (
      input  start, d, sout_ready,
      output sout, sout_valid, busy, done
   );
endinterface

// File: rtl/reg8_serial_reader.sv
// rtl/reg8_serial_reader.sv - captures a parallel register word and streams it out MSB first
// Optional even-parity trailer bit when PARITY_EN is defined.
module reg8_serial_reader #(
   parameter int WIDTH = 8
) (
   input logic                 clk_i,
   input logic                 reset_ni,
   reg8_serial_reader_if.slave bus
);
   localparam int              CW       = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]   LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
`ifdef PARITY_EN
      PAR   = 2'd2,
`endif
      DONE  = 2'd3
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] shift_q;
   logic [CW-1:0]    cnt_q;
   logic             sout_q;
   logic             sout_valid_q;
   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] shift_d;
   logic             xfer;

   assign shift_d = {shift_q[WIDTH-2:0], 1'b0};
   assign xfer    = sout_valid_q && bus.sout_ready;

`ifdef PARITY_EN
   logic parity_q;
   logic parity_d;
   assign parity_d = parity_q ^ shift_q[WIDTH-1];
`endif

   // Outputs are registered so sout/sout_valid always describe the bit on offer this cycle.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q      <= IDLE;
         shift_q      <= '0;
         cnt_q        <= '0;
         sout_q       <= 1'b0;
         sout_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
`ifdef PARITY_EN
         parity_q     <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  shift_q      <= bus.d;
                  cnt_q        <= '0;
                  sout_q       <= bus.d[WIDTH-1];
                  sout_valid_q <= 1'b1;
                  busy_q       <= 1'b1;
                  state_q      <= SHIFT;
`ifdef PARITY_EN
                  parity_q     <= 1'b0;
`endif
               end
            end
            SHIFT: begin
               if (xfer) begin
                  shift_q <= shift_d;
                  cnt_q   <= cnt_q + CW'(1);
`ifdef PARITY_EN
                  parity_q <= parity_d;
`endif
                  if (cnt_q == LAST_BIT) begin
`ifdef PARITY_EN
                     sout_q  <= parity_d;
                     state_q <= PAR;
`else
                     sout_q       <= 1'b0;
                     sout_valid_q <= 1'b0;
                     done_q       <= 1'b1;
                     state_q      <= DONE;
`endif
                  end else begin
                     sout_q <= shift_d[WIDTH-1];
                  end
               end
            end
`ifdef PARITY_EN
            PAR: begin
               if (xfer) begin
                  sout_q       <= 1'b0;
                  sout_valid_q <= 1'b0;
                  done_q       <= 1'b1;
                  state_q      <= DONE;
               end
            end
`endif
            DONE: begin
               // start is deliberately not looked at here; only IDLE accepts requests.
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               sout_q       <= 1'b0;
               sout_valid_q <= 1'b0;
               done_q       <= 1'b0;
               busy_q       <= 1'b0;
               state_q      <= IDLE;
            end
         endcase
      end
   end

   assign bus.sout       = sout_q;
   assign bus.sout_valid = sout_valid_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
endmodule

// File: tb/tb_reg8_serial_reader.sv
// tb/tb_reg8_serial_reader.sv - scoreboard bench for reg8_serial_reader
// Expected bits are queued at request time and consumed by a negedge monitor.
module tb_reg8_serial_reader;
   localparam int WIDTH = 8;
`ifdef PARITY_EN
   localparam int LEN = WIDTH + 1;
`else
   localparam int LEN = WIDTH;
`endif

   logic clk_i    = 1'b0;
   logic reset_ni = 1'b0;

   reg8_serial_reader_if #(.WIDTH(WIDTH)) bus ();

   reg8_serial_reader #(.WIDTH(WIDTH)) dut (
      .clk_i    (clk_i),
      .reset_ni (reset_ni),
      .bus      (bus)
   );

   always #5 clk_i = ~clk_i;

   int checks = 0;
   int passed = 0;
   bit exp_q[$];
   int ready_mode = 0;
   int xfers = 0;
   int dones = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
   endtask

   // Reference model: data bits MSB first, then even parity of the whole word.
   task automatic push_word(input logic [WIDTH-1:0] w);
      for (int i = WIDTH - 1; i >= 0; i--) exp_q.push_back(w[i]);
`ifdef PARITY_EN
      exp_q.push_back(^w);
`endif
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      bus.sout_ready = 1'b0;
      forever begin
         tick();
         case (ready_mode)
            0:       bus.sout_ready = 1'b1;
            1:       bus.sout_ready = ~bus.sout_ready;
            default: bus.sout_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   initial begin
      bit prev_stall = 0;
      bit prev_sout  = 0;
      bit prev_done  = 0;
      int bits_in_word = 0;
      forever begin
         @(negedge clk_i);
         if (!reset_ni) begin
            prev_stall   = 0;
            prev_done    = 0;
            bits_in_word = 0;
         end else begin
            if (!bus.sout_valid) check("sout_zero_when_invalid", 32'(bus.sout), 32'd0);
            if (prev_stall) begin
               check("stall_hold_valid", 32'(bus.sout_valid), 32'd1);
               check("stall_hold_sout", 32'(bus.sout), 32'(prev_sout));
            end
            if (bus.sout_valid && bus.sout_ready) begin
               if (exp_q.size() == 0) check("transfer_with_empty_queue", 32'(exp_q.size()), 32'd1);
               else check("serial_bit", 32'(bus.sout), 32'(exp_q.pop_front()));
               xfers++;
               bits_in_word++;
            end
            if (bus.done) begin
               check("word_length", 32'(bits_in_word), 32'(LEN));
               check("busy_in_done", 32'(bus.busy), 32'd1);
               check("done_single_cycle", 32'(prev_done), 32'd0);
               bits_in_word = 0;
               dones++;
            end
            prev_stall = bus.sout_valid && !bus.sout_ready;
            prev_sout  = bus.sout;
            prev_done  = bus.done;
         end
      end
   end

   task automatic send(input logic [WIDTH-1:0] w, input bit chk_lat);
      int k;
      k = 0;
      while (bus.busy && k < 200) begin tick(); k++; end
      if (k >= 200) check("wait_idle_timeout", 32'(k), 32'd0);
      push_word(w);
      bus.d     = w;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      bus.d     = WIDTH'($urandom);
      check("busy_after_start", 32'(bus.busy), 32'd1);
      if (chk_lat) check("first_bit_valid", 32'(bus.sout_valid), 32'd1);
      k = 0;
      while (!bus.done && k < 1000) begin tick(); k++; end
      if (chk_lat) check("done_latency", 32'(k), 32'(LEN));
      else check("done_seen", 32'(bus.done), 32'd1);
      tick();
      check("busy_cleared", 32'(bus.busy), 32'd0);
   endtask

   initial begin
      int k;
      int d0;
      int t[$];
      bus.start = 1'b1;
      bus.d     = 8'hFF;
      #12;
      check("reset_sout", 32'(bus.sout), 32'd0);
      check("reset_valid", 32'(bus.sout_valid), 32'd0);
      check("reset_busy", 32'(bus.busy), 32'd0);
      check("reset_done", 32'(bus.done), 32'd0);
      bus.start = 1'b0;
      @(negedge clk_i);
      reset_ni = 1'b1;
      tick();
      check("no_start_after_release", 32'(bus.busy), 32'd0);

      ready_mode = 0;
      send(8'hA5, 1);
      ready_mode = 1;
      send(8'h3C, 0);
      ready_mode = 0;
      send(8'h07, 1);
      send(8'h03, 1);
      ready_mode = 2;
      repeat (10) send(WIDTH'($urandom), 0);
      ready_mode = 0;
      repeat (3) send(WIDTH'($urandom), 1);

      // start pulsed mid-word and during DONE must not queue a second word
      d0 = dones;
      push_word(8'h96);
      bus.d = 8'h96; bus.start = 1'b1; tick(); bus.start = 1'b0;
      repeat (3) tick();
      bus.d = 8'h5A; bus.start = 1'b1; tick(); bus.start = 1'b0;
      k = 0;
      while (!bus.done && k < 100) begin tick(); k++; end
      bus.start = 1'b1; tick(); bus.start = 1'b0;
      repeat (6) tick();
      check("no_queued_request_busy", 32'(bus.busy), 32'd0);
      check("no_queued_request_dones", 32'(dones), 32'(d0 + 1));

      // reset mid-word after the third transfer of 8'hFF
      d0 = xfers;
      push_word(8'hFF);
      bus.d = 8'hFF; bus.start = 1'b1; tick(); bus.start = 1'b0;
      k = 0;
      while (xfers < d0 + 3 && k < 100) begin tick(); k++; end
      check("three_bits_before_reset", 32'(xfers), 32'(d0 + 3));
      #2 reset_ni = 1'b0;
      #1;
      check("async_reset_sout", 32'(bus.sout), 32'd0);
      check("async_reset_valid", 32'(bus.sout_valid), 32'd0);
      check("async_reset_busy", 32'(bus.busy), 32'd0);
      check("async_reset_done", 32'(bus.done), 32'd0);
      exp_q.delete();
      d0 = dones;
      repeat (2) tick();
      #3 reset_ni = 1'b1;
      tick();
      repeat (4) tick();
      check("no_done_after_abort", 32'(dones), 32'(d0));
      check("idle_after_abort", 32'(bus.busy), 32'd0);
      send(8'h81, 1);

      // start held high: back-to-back words with DONE + one IDLE cycle between
      d0 = dones;
      repeat (3) push_word(8'h55);
      bus.d = 8'h55; bus.start = 1'b1;
      k = 0;
      while (t.size() < 3 && k < 200) begin
         tick();
         k++;
         if (bus.done) begin
            t.push_back(k);
            if (t.size() == 3) bus.start = 1'b0;
         end
      end
      bus.start = 1'b0;
      check("held_start_words", 32'(t.size()), 32'd3);
      if (t.size() == 3) begin
         check("held_start_gap1", 32'(t[1] - t[0]), 32'(LEN + 2));
         check("held_start_gap2", 32'(t[2] - t[1]), 32'(LEN + 2));
      end
      repeat (6) tick();
      check("held_start_idle", 32'(bus.busy), 32'd0);
      check("held_start_dones", 32'(dones), 32'(d0 + 3));

      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
